// File: rtl/ysyx_23060061_pkg.sv
// ysyx_23060061_pkg: shared LSU definitions.
//   lsu_state_t  FSM state encoding (IDLE, REQ, WAIT, DONE)
//   SZ_B/SZ_H    access size taken from funct3[1:0]; any other value is a word
//   misaligned() true when a half/word access is not naturally aligned
package ysyx_23060061_pkg;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} lsu_state_t;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;

    // funct3 011/110/111 fall into the word case on purpose
    function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] addr);
        return funct3[1:0] == SZ_B ? 1'b0 : funct3[1:0] == SZ_H ? addr[0] : |addr;
    endfunction

endpackage

// File: rtl/ysyx_23060061_LoadExt.sv
// ysyx_23060061_LoadExt: selects and extends load data from a 32-bit bus word.
//   rdata   in   raw word returned by memory
//   addr    in   byte offset within the word
//   funct3  in   RV32 load funct3 (bit 2 set = zero-extend)
//   data    out  extended load result
module ysyx_23060061_LoadExt
    import ysyx_23060061_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rdata,
    input  logic [1:0]       addr,
    input  logic [2:0]       funct3,
    output logic [WIDTH-1:0] data
);

    logic [7:0]  b;
    logic [15:0] h;

    // halfword select ignores addr[0]; misaligned halves never reach the bus
    always_comb begin
        b    = rdata[{addr, 3'b000} +: 8];
        h    = addr[1] ? rdata[31:16] : rdata[15:0];
        data = funct3[1:0] == SZ_B ? {{24{~funct3[2] & b[7]}}, b} :
               funct3[1:0] == SZ_H ? {{16{~funct3[2] & h[15]}}, h} : rdata;
    end

endmodule

// File: rtl/ysyx_23060061_lsu.sv
// ysyx_23060061_lsu: load/store unit between execute and writeback.
//   clk, rst_n                      clock, synchronous active-low reset
//   in_valid/in_ready               upstream handshake; in_addr, in_wdata,
//                                   in_load, in_store, in_funct3 operation
//   mem_req_valid/mem_req_ready     request channel; mem_addr, mem_wen,
//                                   mem_wdata, mem_wstrb request fields
//   mem_resp_valid, mem_rdata       response channel (always accepted in WAIT)
//   out_valid/out_ready             downstream handshake; out_data, out_misalign
module ysyx_23060061_lsu
    import ysyx_23060061_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_addr,
    input  logic [WIDTH-1:0] in_wdata,
    input  logic             in_load,
    input  logic             in_store,
    input  logic [2:0]       in_funct3,
    output logic             mem_req_valid,
    input  logic             mem_req_ready,
    output logic [WIDTH-1:0] mem_addr,
    output logic             mem_wen,
    output logic [WIDTH-1:0] mem_wdata,
    output logic [3:0]       mem_wstrb,
    input  logic             mem_resp_valid,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_misalign
);

    lsu_state_t       state, state_n;
    logic [WIDTH-1:0] addr, wdata, result, load_data;
    logic [2:0]       funct3;
    logic             store, misal;
    logic             in_mem, in_misal;

    assign in_mem   = in_load | in_store;
    assign in_misal = in_mem & misaligned(in_funct3, in_addr[1:0]);

    ysyx_23060061_LoadExt #(.WIDTH(WIDTH)) u_ext (
        .rdata  (mem_rdata),
        .addr   (addr[1:0]),
        .funct3 (funct3),
        .data   (load_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            addr   <= '0;
            wdata  <= '0;
            funct3 <= '0;
            store  <= 1'b0;
            result <= '0;
            misal  <= 1'b0;
        end else begin
            state <= state_n;
            if (state == IDLE && in_valid) begin
                addr   <= in_addr;
                wdata  <= in_wdata;
                funct3 <= in_funct3;
                store  <= in_store;
                result <= in_mem ? '0 : in_addr;
                misal  <= in_misal;
            end
            if (state == WAIT && mem_resp_valid)
                result <= store ? '0 : load_data;
        end
    end

    always_comb begin
        state_n       = state;
        in_ready      = state == IDLE;
        mem_req_valid = state == REQ;
        mem_addr      = {addr[WIDTH-1:2], 2'b00};
        mem_wen       = state == REQ && store;
        mem_wdata     = funct3[1:0] == SZ_B ? {4{wdata[7:0]}} :
                        funct3[1:0] == SZ_H ? {2{wdata[15:0]}} : wdata;
        mem_wstrb     = !(state == REQ && store) ? 4'b0000 :
                        funct3[1:0] == SZ_B ? 4'b0001 << addr[1:0] :
                        funct3[1:0] == SZ_H ? 4'b0011 << addr[1:0] : 4'b1111;
        out_valid     = state == DONE;
        out_data      = result;
        out_misalign  = misal;
        unique case (state)
            IDLE: if (in_valid) state_n = (in_mem && !in_misal) ? REQ : DONE;
            REQ:  if (mem_req_ready) state_n = WAIT;
            WAIT: if (mem_resp_valid) state_n = DONE;
            DONE: if (out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ysyx_23060061_lsu.sv
// tb_ysyx_23060061_lsu: directed self-checking bench for ysyx_23060061_lsu.
module tb_ysyx_23060061_lsu;

    logic        clk;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [31:0] in_addr, in_wdata;
    logic        in_load, in_store;
    logic [2:0]  in_funct3;
    logic        mem_req_valid, mem_req_ready;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_wen;
    logic [3:0]  mem_wstrb;
    logic        mem_resp_valid;
    logic [31:0] mem_rdata;
    logic        out_valid, out_ready;
    logic [31:0] out_data;
    logic        out_misalign;

    int checks = 0;
    int failures = 0;

    ysyx_23060061_lsu #(.WIDTH(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_addr        (in_addr),
        .in_wdata       (in_wdata),
        .in_load        (in_load),
        .in_store       (in_store),
        .in_funct3      (in_funct3),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_addr       (mem_addr),
        .mem_wen        (mem_wen),
        .mem_wdata      (mem_wdata),
        .mem_wstrb      (mem_wstrb),
        .mem_resp_valid (mem_resp_valid),
        .mem_rdata      (mem_rdata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_misalign   (out_misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
        in_valid  = 1'b1;
        in_load   = ld;
        in_store  = st;
        in_funct3 = f3;
        in_addr   = a;
        in_wdata  = wd;
        step();
        in_valid  = 1'b0;
    endtask

    task automatic retire(input string tag);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, "_ovalid_clr"}, out_valid, 0);
        chk({tag, "_inready"}, in_ready, 1);
    endtask

    task automatic run_op(input string tag, input logic ld, input logic st, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                          input logic [31:0] exp_wdata, input logic [3:0] exp_strb,
                          input logic [31:0] exp_out);
        issue(ld, st, f3, a, wd);
        chk({tag, "_reqv"}, mem_req_valid, 1);
        chk({tag, "_maddr"}, mem_addr, {a[31:2], 2'b00});
        chk({tag, "_wen"}, mem_wen, st);
        if (st) chk({tag, "_wdata"}, mem_wdata, exp_wdata);
        chk({tag, "_wstrb"}, mem_wstrb, exp_strb);
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        chk({tag, "_reqv_clr"}, mem_req_valid, 0);
        chk({tag, "_wait"}, out_valid, 0);
        mem_resp_valid = 1'b1;
        mem_rdata      = rd;
        step();
        mem_resp_valid = 1'b0;
        chk({tag, "_ovalid"}, out_valid, 1);
        chk({tag, "_data"}, out_data, exp_out);
        chk({tag, "_misal"}, out_misalign, 0);
        retire(tag);
    endtask

    task automatic run_misal(input string tag, input logic ld, input logic st,
                             input logic [2:0] f3, input logic [31:0] a);
        issue(ld, st, f3, a, 32'hFFFF_FFFF);
        chk({tag, "_noreq"}, mem_req_valid, 0);
        chk({tag, "_ovalid"}, out_valid, 1);
        chk({tag, "_misal"}, out_misalign, 1);
        chk({tag, "_data"}, out_data, 0);
        retire(tag);
    endtask

    initial begin
        rst_n          = 1'b0;
        in_valid       = 1'b0;
        in_addr        = '0;
        in_wdata       = '0;
        in_load        = 1'b0;
        in_store       = 1'b0;
        in_funct3      = '0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_rdata      = '0;
        out_ready      = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("rst_inready", in_ready, 1);
        chk("rst_reqv", mem_req_valid, 0);
        chk("rst_wen", mem_wen, 0);
        chk("rst_wstrb", mem_wstrb, 0);
        chk("rst_ovalid", out_valid, 0);
        chk("rst_odata", out_data, 0);
        chk("rst_misal", out_misalign, 0);

        // pass-through, one cycle to out_valid, no bus traffic
        issue(1'b0, 1'b0, 3'b010, 32'h1234_5678, 32'h0);
        chk("pt_ovalid", out_valid, 1);
        chk("pt_data", out_data, 32'h1234_5678);
        chk("pt_noreq", mem_req_valid, 0);
        chk("pt_inready", in_ready, 0);
        chk("pt_misal", out_misalign, 0);
        retire("pt");
        issue(1'b0, 1'b0, 3'b010, 32'h0000_0003, 32'h0);
        chk("pt2_data", out_data, 32'h0000_0003);
        chk("pt2_misal", out_misalign, 0);
        retire("pt2");

        run_op("lb",   1'b1, 1'b0, 3'b000, 32'h8000_0003, 32'h0, 32'h80FF_1122, 32'h0, 4'b0000, 32'hFFFF_FF80);
        run_op("lbu",  1'b1, 1'b0, 3'b100, 32'h8000_0003, 32'h0, 32'h80FF_1122, 32'h0, 4'b0000, 32'h0000_0080);
        run_op("lb1",  1'b1, 1'b0, 3'b000, 32'h8000_0001, 32'h0, 32'h0000_7F00, 32'h0, 4'b0000, 32'h0000_007F);
        run_op("lh",   1'b1, 1'b0, 3'b001, 32'h8000_0002, 32'h0, 32'h80FF_1122, 32'h0, 4'b0000, 32'hFFFF_80FF);
        run_op("lhu",  1'b1, 1'b0, 3'b101, 32'h8000_0002, 32'h0, 32'h80FF_1122, 32'h0, 4'b0000, 32'h0000_80FF);
        run_op("lw",   1'b1, 1'b0, 3'b010, 32'h8000_0004, 32'h0, 32'hDEAD_BEEF, 32'h0, 4'b0000, 32'hDEAD_BEEF);
        run_op("l111", 1'b1, 1'b0, 3'b111, 32'h8000_0008, 32'h0, 32'h8000_0001, 32'h0, 4'b0000, 32'h8000_0001);
        run_op("sh",   1'b0, 1'b1, 3'b001, 32'h8000_0002, 32'hAAAA_BEEF, 32'hFFFF_FFFF, 32'hBEEF_BEEF, 4'b1100, 32'h0);
        run_op("sb",   1'b0, 1'b1, 3'b000, 32'h8000_0001, 32'h1234_5678, 32'hFFFF_FFFF, 32'h7878_7878, 4'b0010, 32'h0);
        run_op("sw",   1'b0, 1'b1, 3'b010, 32'h8000_000C, 32'hCAFE_F00D, 32'hFFFF_FFFF, 32'hCAFE_F00D, 4'b1111, 32'h0);
        run_op("ldst", 1'b1, 1'b1, 3'b000, 32'h8000_0003, 32'h0000_00A5, 32'h8000_0000, 32'hA5A5_A5A5, 4'b1000, 32'h0);

        run_misal("mlw", 1'b1, 1'b0, 3'b010, 32'h8000_0006);
        run_misal("mlh", 1'b1, 1'b0, 3'b001, 32'h8000_0001);
        run_misal("msw", 1'b0, 1'b1, 3'b010, 32'h8000_0002);

        // request backpressure, early response ignored, then output backpressure
        issue(1'b1, 1'b0, 3'b010, 32'h8000_0010, 32'h0);
        for (int i = 0; i < 5; i++) begin
            chk("bp_reqv", mem_req_valid, 1);
            chk("bp_maddr", mem_addr, 32'h8000_0010);
            chk("bp_wen", mem_wen, 0);
            chk("bp_wstrb", mem_wstrb, 0);
            step();
        end
        chk("bp_reqv_hold", mem_req_valid, 1);
        mem_req_ready  = 1'b1;
        mem_resp_valid = 1'b1;
        mem_rdata      = 32'hBAD0_BAD0;
        step();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        chk("bp_early_ovalid", out_valid, 0);
        chk("bp_reqv_clr", mem_req_valid, 0);
        step();
        chk("bp_still_wait", out_valid, 0);
        mem_resp_valid = 1'b1;
        mem_rdata      = 32'h1122_3344;
        step();
        mem_resp_valid = 1'b0;
        mem_rdata      = 32'h5555_AAAA;
        for (int i = 0; i < 3; i++) begin
            chk("bp_ovalid", out_valid, 1);
            chk("bp_odata", out_data, 32'h1122_3344);
            chk("bp_omisal", out_misalign, 0);
            chk("bp_noreq", mem_req_valid, 0);
            step();
        end
        retire("bp");
        step();
        chk("bp_single", mem_req_valid, 0);

        // reset while waiting for a response, then a stale response arrives
        issue(1'b1, 1'b0, 3'b010, 32'h8000_0020, 32'h0);
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        chk("rw_inwait", in_ready, 0);
        rst_n = 1'b0;
        step();
        chk("rw_rst_inready", in_ready, 1);
        rst_n          = 1'b1;
        mem_resp_valid = 1'b1;
        mem_rdata      = 32'h7777_7777;
        step();
        mem_resp_valid = 1'b0;
        chk("rw_inready", in_ready, 1);
        chk("rw_ovalid", out_valid, 0);
        chk("rw_odata", out_data, 0);
        step();
        chk("rw_ovalid2", out_valid, 0);
        chk("rw_reqv", mem_req_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
